packet_header_builder: RTL and testbench

- Inverse of the monitoring path's packet analyzer: takes one attribute record per packet and emits a synthetic Ethernet/IPv4(/UDP|TCP) frame on an AXI4-Stream master.
- Record layout is the analyzer's output layout: {input_port, prtcl_id, pkt_flags, bytes, l4 dst port, l4 src port, dst ip, src ip, proto}.
- Sits in the generator path; lets captured or host-written attributes be replayed as real frames.
- Payload bytes are zero. Header fields are derived from the record.

---
 rtl/packet_header_builder.sv | 171 +++++++++++++++++
 tb/tb_packet_header_builder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_header_builder.sv
// Builds a synthetic Ethernet/IPv4(/UDP|TCP) frame from one attribute record and
// streams it out on an AXI4-Stream master; payload bytes are zero.
module packet_header_builder #(
  parameter int          C_M_AXIS_DATA_WIDTH  = 256,
  parameter int          C_M_AXIS_TUSER_WIDTH = 128,
  parameter int          ATTRIBUTE_DATA_WIDTH = 135,
  parameter int          MIN_FRAME_BYTES      = 60,
  parameter int          MAX_FRAME_BYTES      = 1514,
  parameter logic [47:0] SRC_MAC              = 48'h000000000001,
  parameter logic [47:0] DST_MAC              = 48'h000000000002
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [ATTRIBUTE_DATA_WIDTH-1:0]      in_attributes,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic [31:0]                          pkt_count
);

  localparam int          DW    = C_M_AXIS_DATA_WIDTH;
  localparam int          SW    = C_M_AXIS_DATA_WIDTH / 8;
  localparam int          TW    = C_M_AXIS_TUSER_WIDTH;
  localparam logic [15:0] MIN_L = 16'(MIN_FRAME_BYTES);
  localparam logic [15:0] MAX_L = 16'(MAX_FRAME_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SEND} state_t;

  state_t                          state_q, state_d;
  logic                            ready_q;
  logic [10:0]                     w_q, w_d;
  logic [31:0]                     cnt_q, cnt_d;
  logic [ATTRIBUTE_DATA_WIDTH-1:0] rec_q;
  logic [2*DW-1:0]                 hdr_q, hdr_d;
  logic [10:0]                     nwords_q, nwords_d;
  logic [SW-1:0]                   strb_last_q, strb_last_d;
  logic [TW-1:0]                   tuser_q, tuser_d;
  logic                            accept, last_word;

  logic [7:0]  proto, port;
  logic [31:0] src_ip, dst_ip;
  logic [15:0] sport, dport, bytes;
  logic [4:0]  flags;
  logic        unused_prtcl;

  assign proto        = rec_q[7:0];
  assign src_ip       = rec_q[39:8];
  assign dst_ip       = rec_q[71:40];
  assign sport        = rec_q[87:72];
  assign dport        = rec_q[103:88];
  assign bytes        = rec_q[119:104];
  assign flags        = rec_q[124:120];
  assign port         = rec_q[134:127];
  assign unused_prtcl = ^rec_q[126:125];

  logic [15:0]  len, tot_len, udp_len;
  logic [4:0]   rem;
  logic [19:0]  csum_sum;
  logic [16:0]  csum_fold1;
  logic [15:0]  csum_fold2, csum;
  logic [159:0] l4;

  // Length clamp feeds every length-derived field below
  always_comb begin
    if (bytes < MIN_L)      len = MIN_L;
    else if (bytes > MAX_L) len = MAX_L;
    else                    len = bytes;
  end

  assign tot_len     = len - 16'd14;
  assign udp_len     = len - 16'd34;
  assign nwords_d    = 11'((len + 16'd31) >> 5);
  assign rem         = len[4:0];
  assign strb_last_d = (rem == 5'd0) ? {SW{1'b1}} : ~({SW{1'b1}} >> rem);

  // Header checksum over the ten 16-bit words with the checksum field as zero
  assign csum_sum   = 20'h04500 + 20'(tot_len) + 20'h04000 + 20'({8'd64, proto})
                    + 20'(src_ip[31:16]) + 20'(src_ip[15:0])
                    + 20'(dst_ip[31:16]) + 20'(dst_ip[15:0]);
  assign csum_fold1 = 17'(csum_sum[15:0]) + 17'(csum_sum[19:16]);
  assign csum_fold2 = csum_fold1[15:0] + 16'(csum_fold1[16]);
  assign csum       = ~csum_fold2;

  always_comb begin
    l4 = '0;
    if (proto == 8'd17)
      l4 = {sport, dport, udp_len, 16'h0000, 96'h0};
    else if (proto == 8'd6)
      l4 = {sport, dport, 32'h0, 32'h0, 8'h50, 3'b000, flags, 16'hFFFF, 32'h0};
    hdr_d = {DST_MAC, SRC_MAC, 16'h0800, 8'h45, 8'h00, tot_len, 16'h0000, 16'h4000,
             8'd64, proto, csum, src_ip, dst_ip, l4, 80'h0};
  end

  always_comb begin
    tuser_d        = '0;
    tuser_d[15:0]  = len;
    tuser_d[23:16] = port;
  end

  assign accept    = in_valid && ready_q;
  assign last_word = (w_q == nwords_q - 11'd1);

  always_comb begin
    state_d       = state_q;
    w_d           = w_q;
    cnt_d         = cnt_q;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tstrb  = '0;
    m_axis_tuser  = '0;
    case (state_q)
      S_IDLE: if (accept) state_d = S_CALC;
      S_CALC: begin
        state_d = S_SEND;
        w_d     = '0;
      end
      S_SEND: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = last_word;
        m_axis_tuser  = tuser_q;
        m_axis_tstrb  = last_word ? strb_last_q : {SW{1'b1}};
        if (w_q == 11'd0)      m_axis_tdata = hdr_q[2*DW-1:DW];
        else if (w_q == 11'd1) m_axis_tdata = hdr_q[DW-1:0];
        if (m_axis_tready) begin
          if (last_word) begin
            state_d = S_IDLE;
            cnt_d   = cnt_q + 32'd1;
          end else begin
            w_d = w_q + 11'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state; ready is registered so it stays low through reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      w_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_IDLE);
      w_q     <= w_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) rec_q <= in_attributes;
    if (state_q == S_CALC) begin
      hdr_q       <= hdr_d;
      nwords_q    <= nwords_d;
      strb_last_q <= strb_last_d;
      tuser_q     <= tuser_d;
    end
  end

  assign in_ready  = ready_q;
  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_packet_header_builder.sv
// Bench for packet_header_builder: byte-level frame model, per-cycle compare, directed and random records.
module tb_packet_header_builder;

  localparam logic [47:0] SMAC = 48'h000000000001;
  localparam logic [47:0] DMAC = 48'h000000000002;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [134:0] in_attributes;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [31:0]  pkt_count;

  packet_header_builder dut (
    .clk(clk), .reset_n(reset_n), .in_attributes(in_attributes), .in_valid(in_valid),
    .in_ready(in_ready), .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb),
    .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit rnd_ready = 1'b0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame model: the whole frame as a byte array
  logic [7:0]  fb [0:1535];
  int          mL, mNW;
  logic [7:0]  mPort;

  function automatic void put16(input int idx, input int v);
    fb[idx]   = 8'(v >> 8);
    fb[idx+1] = 8'(v);
  endfunction

  function automatic void build(input logic [134:0] r);
    int b, s;
    logic [7:0] pr;
    b = int'(r[119:104]);
    if (b < 60) b = 60;
    else if (b > 1514) b = 1514;
    mL = b; mNW = (b + 31) / 32; mPort = r[134:127]; pr = r[7:0];
    for (int i = 0; i < 1536; i++) fb[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fb[i]   = 8'(DMAC >> (8 * (5 - i)));
      fb[6+i] = 8'(SMAC >> (8 * (5 - i)));
    end
    put16(12, 'h0800);
    fb[14] = 8'h45;
    put16(16, b - 14);
    put16(20, 'h4000);
    fb[22] = 8'd64;
    fb[23] = pr;
    for (int k = 0; k < 4; k++) begin
      fb[26+k] = 8'(r[39:8] >> (8 * (3 - k)));
      fb[30+k] = 8'(r[71:40] >> (8 * (3 - k)));
    end
    s = 0;
    for (int i = 14; i < 34; i += 2) s = s + int'({fb[i], fb[i+1]});
    while (s > 'hFFFF) s = (s & 'hFFFF) + (s >> 16);
    put16(24, (~s) & 'hFFFF);
    if (pr == 8'd17 || pr == 8'd6) begin
      put16(34, int'(r[87:72]));
      put16(36, int'(r[103:88]));
    end
    if (pr == 8'd17) put16(38, b - 34);
    if (pr == 8'd6) begin
      fb[46] = 8'h50;
      fb[47] = {3'b000, r[124:120]};
      put16(48, 'hFFFF);
    end
  endfunction

  function automatic logic [134:0] mk(input logic [7:0] port, input logic [1:0] prt,
                                      input logic [4:0] flags, input logic [15:0] bytes,
                                      input logic [15:0] sport, input logic [15:0] dport,
                                      input logic [31:0] src, input logic [31:0] dst,
                                      input logic [7:0] proto);
    return {port, prt, flags, bytes, dport, sport, dst, src, proto};
  endfunction

  // Per-cycle compare against the model
  bit           pending = 1'b0;
  int           cyc = 0, start_cyc = 0, widx = 0, since_rst = 0, hs = 0;
  logic [31:0]  mcount = '0;
  int           last_nw = 0;
  logic [31:0]  last_strb = '0;
  logic [255:0] last_w0 = '0, last_w1 = '0;
  logic [127:0] last_tuser = '0;
  logic [255:0] ed;
  logic [31:0]  es;
  bit           exp_v;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_pkt_count", pkt_count, 0);
      chk("rst_tdata", m_axis_tdata, 0);
      chk("rst_tstrb", m_axis_tstrb, 0);
      chk("rst_tuser", m_axis_tuser, 0);
      pending = 1'b0; mcount = '0; since_rst = 0; hs = 0;
    end else begin
      cyc++;
      if (since_rst < 10) since_rst++;
      exp_v = pending && (cyc >= start_cyc);
      chk("tvalid", m_axis_tvalid, exp_v);
      chk("pkt_count", pkt_count, mcount);
      if (pending) chk("in_ready_busy", in_ready, 0);
      else if (since_rst >= 2) chk("in_ready_idle", in_ready, 1);
      if (m_axis_tvalid && exp_v) begin
        for (int j = 0; j < 32; j++) begin
          ed[255-8*j -: 8] = fb[32*widx+j];
          es[31-j]         = (32 * widx + j < mL);
        end
        chk("tdata", m_axis_tdata, ed);
        chk("tstrb", m_axis_tstrb, es);
        chk("tlast", m_axis_tlast, widx == mNW - 1);
        chk("tuser", m_axis_tuser, {104'h0, mPort, 16'(mL)});
        if (m_axis_tready) begin
          if (widx == 0) last_w0 = m_axis_tdata;
          if (widx == 1) last_w1 = m_axis_tdata;
          if (widx == mNW - 1) begin
            mcount++;
            pending = 1'b0;
          end else begin
            widx++;
          end
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        hs++;
        if (m_axis_tlast) begin
          last_nw = hs; hs = 0;
          last_strb = m_axis_tstrb;
          last_tuser = m_axis_tuser;
        end
      end
      if (in_valid && in_ready) begin
        build(in_attributes);
        pending = 1'b1; start_cyc = cyc + 2; widx = 0;
      end
    end
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = rnd_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  task automatic send_rec(input logic [134:0] r);
    int n;
    @(posedge clk); #1;
    in_attributes = r;
    in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 5000);
    chk("accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while ((pending || m_axis_tvalid) && n < 5000);
    chk("done_timeout", pending, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pr;
    logic [15:0] tb_bytes;
    int          sel;
    in_valid = 1'b0;
    in_attributes = '0;

    // Literal pins on the model itself
    build(mk(0, 0, 0, 16'd129, 0, 0, 32'hC0A80001, 32'hC0A800C7, 8'd17));
    chk("model_csum", {fb[24], fb[25]}, 16'hB861);
    chk("model_totlen129", {fb[16], fb[17]}, 16'h0073);
    build(mk(0, 0, 0, 16'd40, 0, 0, 0, 0, 8'd17));
    chk("model_clamp_lo", mL, 60);
    chk("model_nw_lo", mNW, 2);
    build(mk(0, 0, 0, 16'd2000, 0, 0, 0, 0, 8'd17));
    chk("model_clamp_hi", mL, 1514);
    chk("model_nw_hi", mNW, 48);
    build(mk(0, 0, 0, 16'd100, 0, 0, 0, 0, 8'd17));
    chk("model_udplen", {fb[38], fb[39]}, 16'h0042);

    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    send_rec(mk(8'd3, 0, 0, 16'd100, 16'h1234, 16'h0035, 32'h0A000001, 32'h0A000002, 8'd17));
    wait_done();
    chk("udp100_words", last_nw, 4);
    chk("udp100_strb", last_strb, 32'hF0000000);
    chk("udp100_totlen", last_w0[127:112], 16'h0056);
    chk("udp100_udplen", last_w1[207:192], 16'h0042);
    chk("udp100_tuser_len", last_tuser[15:0], 16'd100);
    chk("udp100_tuser_port", last_tuser[23:16], 8'd3);
    chk("udp100_count", pkt_count, 1);

    send_rec(mk(8'd1, 0, 0, 16'd40, 16'd1, 16'd2, 32'h01020304, 32'h05060708, 8'd17));
    wait_done();
    chk("b40_words", last_nw, 2);
    chk("b40_strb", last_strb, 32'hFFFFFFF0);
    chk("b40_totlen", last_w0[127:112], 16'h002E);
    send_rec(mk(8'd1, 0, 0, 16'd64, 16'd1, 16'd2, 32'h01020304, 32'h05060708, 8'd1));
    wait_done();
    chk("b64_words", last_nw, 2);
    chk("b64_strb", last_strb, 32'hFFFFFFFF);
    send_rec(mk(8'd9, 0, 0, 16'd2000, 16'd7, 16'd8, 32'h0A0A0A0A, 32'h0B0B0B0B, 8'd17));
    wait_done();
    chk("b2000_words", last_nw, 48);
    chk("b2000_strb", last_strb, 32'hFFC00000);
    chk("b2000_tuser_len", last_tuser[15:0], 16'd1514);
    send_rec(mk(8'd0, 0, 0, 16'd129, 16'd5, 16'd6, 32'hC0A80001, 32'hC0A800C7, 8'd17));
    wait_done();
    chk("csum_hdr", last_w0[143:64], 80'h4500_0073_0000_4000_4011);
    chk("csum_val", last_w0[63:48], 16'hB861);
    chk("count5", pkt_count, 5);

    rnd_ready = 1'b1;
    send_rec(mk(8'd2, 2'd1, 5'h12, 16'd90, 16'd80, 16'd4000, 32'h0A000001, 32'h0A000002, 8'd6));
    send_rec(mk(8'd2, 2'd1, 5'h12, 16'd150, 16'd443, 16'd5000, 32'h0A000003, 32'h0A000004, 8'd6));
    wait_done();
    chk("tcp_flags", last_w1[135:128], 8'h12);
    chk("tcp_offset", last_w1[143:136], 8'h50);
    chk("tcp_count", pkt_count, 7);

    for (int i = 0; i < 25; i++) begin
      sel = $urandom_range(0, 3);
      pr = (sel == 0) ? 8'd17 : (sel == 1) ? 8'd6 : (sel == 2) ? 8'd1 : 8'($urandom);
      tb_bytes = 16'($urandom_range(0, 2100));
      send_rec(mk(8'($urandom), 2'($urandom), 5'($urandom), tb_bytes, 16'($urandom),
                  16'($urandom), $urandom, $urandom, pr));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(posedge clk);
    end
    wait_done();
    chk("rand_count", pkt_count, 32);

    rnd_ready = 1'b0;
    repeat (2) @(posedge clk);
    send_rec(mk(8'd4, 0, 0, 16'd100, 16'd10, 16'd20, 32'h0A000001, 32'h0A000002, 8'd17));
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!m_axis_tvalid && n < 100);
      chk("abort_first_word", m_axis_tvalid, 1);
    end
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("abort_pre_tvalid", m_axis_tvalid, 1);
    chk("abort_pre_tlast", m_axis_tlast, 0);
    reset_n = 1'b0;
    #1;
    chk("abort_tvalid", m_axis_tvalid, 0);
    chk("abort_tlast", m_axis_tlast, 0);
    chk("abort_count", pkt_count, 0);
    chk("abort_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    send_rec(mk(8'd4, 0, 0, 16'd100, 16'd10, 16'd20, 32'h0A000001, 32'h0A000002, 8'd17));
    wait_done();
    chk("post_rst_words", last_nw, 4);
    chk("post_rst_count", pkt_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
